// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, optional zero register and write bypass,
// a per-register busy scoreboard and a sticky write-collision flag.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*AW-1:0]         wa,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
    input  logic [NUM_RD*AW-1:0]         ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] q,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_addr,
    input  logic                         err_clr,
    output logic                         wr_collision
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic [AW-1:0]         wa_arr [NUM_WR];
    logic [DATA_WIDTH-1:0] wd_arr [NUM_WR];
    logic [AW-1:0]         ra_arr [NUM_RD];
    logic [NUM_WR-1:0]     wvalid;
    logic                  rsv_valid;
    logic                  collision;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
            assign wa_arr[gi] = wa[gi*AW +: AW];
            assign wd_arr[gi] = wd[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_unpack
            assign ra_arr[gi] = ra[gi*AW +: AW];
        end
    endgenerate

    // With a zero register, writes to address 0 are discarded before anything else sees them.
    always_comb begin
        wvalid = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wvalid[i] = we[i] && ((ZERO_REG == 0) || (wa_arr[i] != '0));
        end
        rsv_valid = rsv_en && ((ZERO_REG == 0) || (rsv_addr != '0));
    end

    always_comb begin
        collision = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int k = i + 1; k < NUM_WR; k++) begin
                if (wvalid[i] && wvalid[k] && (wa_arr[i] == wa_arr[k])) begin
                    collision = 1'b1;
                end
            end
        end
    end

    // Ascending port order: the highest-index write to an address is the one that lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wvalid[i]) begin
                    regs[wa_arr[i]] <= wd_arr[i];
                end
            end
        end
    end

    // Reserve is applied after release so a same-cycle reserve wins (it is the newer producer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wvalid[i]) begin
                    busy[wa_arr[i]] <= 1'b0;
                end
            end
            if (rsv_valid) begin
                busy[rsv_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_collision <= 1'b0;
        end else if (collision) begin
            wr_collision <= 1'b1;
        end else if (err_clr) begin
            wr_collision <= 1'b0;
        end
    end

    always_comb begin
        q     = '0;
        rbusy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            logic [DATA_WIDTH-1:0] data;
            logic                  bsy;
            data = regs[ra_arr[j]];
            bsy  = busy[ra_arr[j]];
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wvalid[i] && (wa_arr[i] == ra_arr[j])) begin
                        data = wd_arr[i];
                        bsy  = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra_arr[j] == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
            if (!rst_n) begin
                data = '0;
                bsy  = 1'b0;
            end
            q[j*DATA_WIDTH +: DATA_WIDTH] = data;
            rbusy[j]                      = bsy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus and are
// checked every cycle against an array model, plus hand-computed literal expectations.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    we = '0;
    logic [9:0]    wa = '0;
    logic [63:0]   wd = '0;
    logic [9:0]    ra = '0;
    logic          rsv_en = 1'b0;
    logic [4:0]    rsv_addr = '0;
    logic          err_clr = 1'b0;

    logic [63:0]   q_a, q_b;
    logic [1:0]    rbusy_a, rbusy_b;
    logic          coll_a, coll_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .q(q_a), .rbusy(rbusy_a),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .err_clr(err_clr), .wr_collision(coll_a));

    regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .q(q_b), .rbusy(rbusy_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .err_clr(err_clr), .wr_collision(coll_b));

    // Reference model: plain arrays updated by the rules, no knowledge of the RTL structure.
    logic [31:0] mem [NR];
    bit          bsy [NR];
    bit          coll_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                mem[r] = '0;
                bsy[r] = 0;
            end
            coll_m = 0;
        end else begin
            int hits [NR];
            bit set_coll;
            set_coll = 0;
            for (int r = 0; r < NR; r++) hits[r] = 0;
            for (int i = 0; i < 2; i++) begin
                int a;
                a = int'(wa[i*AW +: AW]);
                if (we[i] && a != 0) begin
                    mem[a] = wd[i*DW +: DW];
                    bsy[a] = 0;
                    hits[a]++;
                    if (hits[a] > 1) set_coll = 1;
                end
            end
            if (rsv_en && rsv_addr != 0) bsy[rsv_addr] = 1;
            if (set_coll) coll_m = 1;
            else if (err_clr) coll_m = 0;
        end
    end

    function automatic logic [31:0] exp_q(int j, bit byp);
        int a;
        logic [31:0] r;
        a = int'(ra[j*AW +: AW]);
        if (!rst_n || a == 0) return '0;
        r = mem[a];
        if (byp)
            for (int i = 0; i < 2; i++)
                if (we[i] && int'(wa[i*AW +: AW]) == a) r = wd[i*DW +: DW];
        return r;
    endfunction

    function automatic logic exp_b(int j, bit byp);
        int a;
        logic b;
        a = int'(ra[j*AW +: AW]);
        if (!rst_n || a == 0) return 1'b0;
        b = bsy[a];
        if (byp)
            for (int i = 0; i < 2; i++)
                if (we[i] && int'(wa[i*AW +: AW]) == a) b = 1'b0;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            check($sformatf("model_q%0d_byp", j), q_a[j*DW +: DW], exp_q(j, 1));
            check($sformatf("model_q%0d_nobyp", j), q_b[j*DW +: DW], exp_q(j, 0));
            check($sformatf("model_rbusy%0d_byp", j), 32'(rbusy_a[j]), 32'(exp_b(j, 1)));
            check($sformatf("model_rbusy%0d_nobyp", j), 32'(rbusy_b[j]), 32'(exp_b(j, 0)));
        end
        check("model_coll_byp", 32'(coll_a), 32'(coll_m));
        check("model_coll_nobyp", 32'(coll_b), 32'(coll_m));
    end

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        we[p]           = en;
        wa[p*AW +: AW]  = a;
        wd[p*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        ra[p*AW +: AW] = a;
    endtask

    task automatic clear_ctl();
        we = '0;
        rsv_en = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_rd(0, 5'd3);
        set_rd(1, 5'd7);
        step();
        settle();
        check("reset_q0", q_a[31:0], 32'h0);
        check("reset_q1", q_a[63:32], 32'h0);
        check("reset_rbusy", 32'(rbusy_a), 32'h0);
        check("reset_coll", 32'(coll_a), 32'h0);
        step();
        rst_n = 1'b1;

        // Two independent writes.
        set_wr(0, 1'b1, 5'd3, 32'h1234_5678);
        set_wr(1, 1'b1, 5'd7, 32'hCAFE_F00D);
        settle();
        check("bypass_q0", q_a[31:0], 32'h1234_5678);
        check("nobypass_q0_old", q_b[31:0], 32'h0);
        step();
        clear_ctl();
        settle();
        check("wr_q0", q_b[31:0], 32'h1234_5678);
        check("wr_q1", q_b[63:32], 32'hCAFE_F00D);
        check("wr_nocoll", 32'(coll_a), 32'h0);

        // Zero register ignores write and reservation.
        step();
        set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        rsv_en = 1'b1;
        rsv_addr = 5'd0;
        set_rd(0, 5'd0);
        step();
        clear_ctl();
        settle();
        check("zero_q0", q_a[31:0], 32'h0);
        check("zero_rbusy0", 32'(rbusy_a[0]), 32'h0);

        // Collision: highest port wins, sticky flag, set beats clear.
        step();
        set_wr(0, 1'b1, 5'd9, 32'h1);
        set_wr(1, 1'b1, 5'd9, 32'h2);
        set_rd(0, 5'd9);
        settle();
        check("coll_bypass_q0", q_a[31:0], 32'h2);
        step();
        clear_ctl();
        settle();
        check("coll_q0", q_b[31:0], 32'h2);
        check("coll_set", 32'(coll_a), 32'h1);
        step();
        settle();
        check("coll_sticky", 32'(coll_a), 32'h1);
        step();
        err_clr = 1'b1;
        step();
        clear_ctl();
        settle();
        check("coll_cleared", 32'(coll_a), 32'h0);
        step();
        set_wr(0, 1'b1, 5'd10, 32'h3);
        set_wr(1, 1'b1, 5'd10, 32'h4);
        err_clr = 1'b1;
        step();
        clear_ctl();
        settle();
        check("coll_set_wins", 32'(coll_a), 32'h1);
        step();
        err_clr = 1'b1;
        step();
        clear_ctl();

        // Bypass versus registered visibility.
        set_wr(0, 1'b1, 5'd4, 32'hA5A5_A5A5);
        set_rd(0, 5'd4);
        settle();
        check("byp_same_cycle", q_a[31:0], 32'hA5A5_A5A5);
        check("nobyp_same_cycle", q_b[31:0], 32'h0);
        step();
        clear_ctl();
        settle();
        check("nobyp_next_cycle", q_b[31:0], 32'hA5A5_A5A5);

        // Scoreboard.
        step();
        rsv_en = 1'b1;
        rsv_addr = 5'd6;
        set_rd(0, 5'd6);
        settle();
        check("rsv_same_cycle", 32'(rbusy_a[0]), 32'h0);
        step();
        clear_ctl();
        settle();
        check("rsv_busy", 32'(rbusy_a[0]), 32'h1);
        step();
        set_wr(0, 1'b1, 5'd6, 32'h66);
        settle();
        check("rel_byp_during", 32'(rbusy_a[0]), 32'h0);
        check("rel_nobyp_during", 32'(rbusy_b[0]), 32'h1);
        step();
        clear_ctl();
        settle();
        check("rel_after", 32'(rbusy_b[0]), 32'h0);
        step();
        set_wr(0, 1'b1, 5'd6, 32'h67);
        rsv_en = 1'b1;
        rsv_addr = 5'd6;
        step();
        clear_ctl();
        settle();
        check("rsv_wins", 32'(rbusy_a[0]), 32'h1);
        check("rsv_wins_q", q_a[31:0], 32'h67);

        // Sweep of write/read patterns across both ports.
        for (int k = 1; k < 16; k++) begin
            step();
            set_wr(0, 1'b1, 5'(k), 32'h1000_0000 + 32'(k));
            set_wr(1, 1'b1, 5'(k + 16), ~32'(k));
            set_rd(0, 5'(k - 1));
            set_rd(1, 5'(k + 16));
        end
        step();
        clear_ctl();
        set_rd(0, 5'd15);
        set_rd(1, 5'd31);
        settle();
        check("sweep_q0", q_b[31:0], 32'h1000_000F);
        check("sweep_q1", q_b[63:32], 32'hFFFF_FFF0);

        // Asynchronous reset mid-run.
        step();
        set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        clear_ctl();
        set_rd(1, 5'd5);
        set_rd(0, 5'd6);
        settle();
        check("pre_rst_q1", q_b[63:32], 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        check("async_rst_q1", q_b[63:32], 32'h0);
        check("async_rst_q1_byp", q_a[63:32], 32'h0);
        step();
        rst_n = 1'b1;
        settle();
        check("post_rst_q1", q_b[63:32], 32'h0);
        check("post_rst_rbusy0", 32'(rbusy_b[0]), 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
